// File: rtl/rmii_tx_serializer.sv
// RMII transmit serializer: MII nibbles in, RMII dibits out, with MII TX clock generation
// and inter-packet gap enforcement/monitoring, all on the 50 MHz reference clock.
//
// state | meaning
// IDLE  | no frame; speed latched continuously; waiting for tx_en at a capture edge
// TX    | frame in progress; dibits of each captured nibble streamed back to back
// IPG   | gap timer running; an early tx_en start is accepted but flagged
module rmii_tx_serializer #(
   parameter int IPG_BITS = 96,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             speed_100,
   output logic             mac_tx_clk,
   input  logic [3:0]       mac_txd,
   input  logic             mac_tx_en,
   output logic [1:0]       phy_txd,
   output logic             phy_tx_en,
   output logic             ipg_busy,
   output logic             ipg_err,
   output logic [CNT_W-1:0] frame_cnt
);

   localparam int IPG_SLOTS = IPG_BITS / 2;
   localparam int IPG_W     = (IPG_SLOTS > 1) ? $clog2(IPG_SLOTS) : 1;
   localparam logic [IPG_W-1:0] IPG_LOAD = IPG_W'(IPG_SLOTS - 1);
   localparam logic [3:0]       SLOT_100 = 4'd0;
   localparam logic [3:0]       SLOT_10  = 4'd9;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_TX   = 2'd1,
      S_IPG  = 2'd2
   } state_t;

   state_t           state_q;
   logic             speed_q;
   logic [3:0]       slot_q;
   logic [3:0]       slot_d;
   logic             mtx_clk_q;
   logic [1:0]       nib_hi_q;
   logic [IPG_W-1:0] ipg_cnt_q;
   logic [1:0]       phy_txd_q;
   logic             phy_tx_en_q;
   logic             ipg_busy_q;
   logic             ipg_err_q;
   logic [CNT_W-1:0] frame_cnt_q;

   logic tick;
   logic cap;
   logic hi_edge;
   logic start;

   // tick marks a slot boundary; the 1->0 edge of mac_tx_clk is the capture point
   always_comb begin
      tick    = (slot_q == 4'd0);
      cap     = tick & mtx_clk_q;
      hi_edge = tick & ~mtx_clk_q;
      start   = cap & mac_tx_en;
      slot_d  = slot_q - 4'd1;
      if (tick) begin
         slot_d = speed_q ? SLOT_100 : SLOT_10;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_q    <= 4'd0;
         mtx_clk_q <= 1'b0;
      end else begin
         slot_q <= slot_d;
         if (tick) begin
            mtx_clk_q <= ~mtx_clk_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         speed_q     <= 1'b1;
         nib_hi_q    <= 2'b00;
         ipg_cnt_q   <= '0;
         phy_txd_q   <= 2'b00;
         phy_tx_en_q <= 1'b0;
         ipg_busy_q  <= 1'b0;
         ipg_err_q   <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         ipg_err_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q     <= S_TX;
                  phy_tx_en_q <= 1'b1;
                  phy_txd_q   <= mac_txd[1:0];
                  nib_hi_q    <= mac_txd[3:2];
               end else begin
                  speed_q <= speed_100;
               end
            end
            S_TX: begin
               if (hi_edge) begin
                  phy_txd_q <= nib_hi_q;
               end else if (cap) begin
                  if (mac_tx_en) begin
                     phy_txd_q <= mac_txd[1:0];
                     nib_hi_q  <= mac_txd[3:2];
                  end else begin
                     state_q     <= S_IPG;
                     phy_tx_en_q <= 1'b0;
                     phy_txd_q   <= 2'b00;
                     ipg_busy_q  <= 1'b1;
                     ipg_cnt_q   <= IPG_LOAD;
                     frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                  end
               end
            end
            S_IPG: begin
               if (tick) begin
                  if (ipg_cnt_q == '0) begin
                     // gap fully elapsed: a start on this very edge is legal
                     ipg_busy_q <= 1'b0;
                     if (start) begin
                        state_q     <= S_TX;
                        phy_tx_en_q <= 1'b1;
                        phy_txd_q   <= mac_txd[1:0];
                        nib_hi_q    <= mac_txd[3:2];
                     end else begin
                        state_q <= S_IDLE;
                     end
                  end else if (start) begin
                     ipg_busy_q  <= 1'b0;
                     ipg_err_q   <= 1'b1;
                     state_q     <= S_TX;
                     phy_tx_en_q <= 1'b1;
                     phy_txd_q   <= mac_txd[1:0];
                     nib_hi_q    <= mac_txd[3:2];
                  end else begin
                     ipg_cnt_q <= ipg_cnt_q - IPG_W'(1);
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign mac_tx_clk = mtx_clk_q;
   assign phy_txd    = phy_txd_q;
   assign phy_tx_en  = phy_tx_en_q;
   assign ipg_busy   = ipg_busy_q;
   assign ipg_err    = ipg_err_q;
   assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_rmii_tx_serializer.sv
// Bench for rmii_tx_serializer: expected dibits (one entry per clk) are queued as the MAC
// side is driven and compared whenever the PHY side shows phy_tx_en.
`timescale 1ns/1ps
module tb_rmii_tx_serializer;

   logic        clk;
   logic        rst;
   logic        speed_100;
   logic        mac_tx_clk;
   logic [3:0]  mac_txd;
   logic        mac_tx_en;
   logic [1:0]  phy_txd;
   logic        phy_tx_en;
   logic        ipg_busy;
   logic        ipg_err;
   logic [15:0] frame_cnt;

   rmii_tx_serializer #(.IPG_BITS(96), .CNT_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .speed_100  (speed_100),
      .mac_tx_clk (mac_tx_clk),
      .mac_txd    (mac_txd),
      .mac_tx_en  (mac_tx_en),
      .phy_txd    (phy_txd),
      .phy_tx_en  (phy_tx_en),
      .ipg_busy   (ipg_busy),
      .ipg_err    (ipg_err),
      .frame_cnt  (frame_cnt)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   int         total = 0;
   int         bad   = 0;
   logic [1:0] exp_q[$];
   logic [3:0] frm[$];
   logic       sb_hold;
   int         en_total   = 0;
   int         busy_total = 0;
   int         err_total  = 0;
   int         exp_frames = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (phy_tx_en) en_total++;
         if (ipg_busy)  busy_total++;
         if (ipg_err)   err_total++;
         if (!sb_hold) begin
            if (phy_tx_en) begin
               int have;
               have = (exp_q.size() > 0) ? 1 : 0;
               chk("sb_avail", have, 1);
               if (have == 1) chk("dibit", phy_txd, exp_q.pop_front());
            end else begin
               chk("txd_idle", phy_txd, 2'b00);
            end
         end
      end
   end

   task automatic mac_edge(output int n);
      logic prev;
      int   got;
      prev = mac_tx_clk;
      got  = 0;
      n    = 0;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk);
         #1;
         if (!prev && mac_tx_clk) begin
            n   = i;
            got = 1;
            break;
         end
         prev = mac_tx_clk;
      end
      chk("mtx_rise", got, 1);
   endtask

   task automatic wait_en_low();
      for (int i = 0; i < 600; i++) begin
         @(posedge clk);
         #1;
         if (!phy_tx_en) break;
      end
      chk("en_fall", phy_tx_en, 0);
   endtask

   task automatic wait_busy_low();
      for (int i = 0; i < 1200; i++) begin
         @(posedge clk);
         #1;
         if (!ipg_busy) break;
      end
      chk("busy_fall", ipg_busy, 0);
   endtask

   task automatic reset_mid();
      sb_hold = 1'b1;
      exp_q.delete();
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rmid_en",   phy_tx_en, 0);
      chk("rmid_txd",  phy_txd, 0);
      chk("rmid_mclk", mac_tx_clk, 0);
      chk("rmid_cnt",  frame_cnt, 0);
      chk("rmid_busy", ipg_busy, 0);
      rst        = 1'b0;
      mac_tx_en  = 1'b0;
      mac_txd    = 4'h0;
      exp_frames = 0;
      repeat (3) @(posedge clk);
      #1;
      sb_hold = 1'b0;
   endtask

   task automatic send_frame(input int slot_len, input int toggle_at, input int abort_at);
      int n;
      for (int i = 0; i < frm.size(); i++) begin
         mac_edge(n);
         mac_txd   = frm[i];
         mac_tx_en = 1'b1;
         if (i == toggle_at) speed_100 = ~speed_100;
         if (i == abort_at) begin
            reset_mid();
            return;
         end
         for (int k = 0; k < slot_len; k++) exp_q.push_back(frm[i][1:0]);
         for (int k = 0; k < slot_len; k++) exp_q.push_back(frm[i][3:2]);
      end
      mac_edge(n);
      mac_tx_en = 1'b0;
      mac_txd   = 4'h0;
   endtask

   initial begin
      int n, en0, b0, e0;
      rst       = 1'b1;
      speed_100 = 1'b1;
      mac_txd   = 4'h0;
      mac_tx_en = 1'b0;
      sb_hold   = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("rst_mclk", mac_tx_clk, 0);
      chk("rst_txd",  phy_txd, 0);
      chk("rst_en",   phy_tx_en, 0);
      chk("rst_busy", ipg_busy, 0);
      chk("rst_err",  ipg_err, 0);
      chk("rst_cnt",  frame_cnt, 0);
      rst     = 1'b0;
      sb_hold = 1'b0;

      // 100M, 16 nibbles, then full gap with MAC idle
      frm.delete();
      repeat (11) frm.push_back(4'h5);
      frm.push_back(4'hD);
      frm.push_back(4'h1);
      frm.push_back(4'h2);
      frm.push_back(4'h3);
      frm.push_back(4'h4);
      en0 = en_total; b0 = busy_total; e0 = err_total;
      send_frame(1, -1, -1);
      wait_en_low();
      exp_frames++;
      chk("t1_cnt", frame_cnt, exp_frames);
      chk("t1_en_len", en_total - en0, 32);
      wait_busy_low();
      chk("t1_ipg_len", busy_total - b0, 48);
      chk("t1_no_err", err_total - e0, 0);
      chk("t1_sb_empty", exp_q.size(), 0);

      // 10M single nibble
      speed_100 = 1'b0;
      repeat (30) @(posedge clk);
      mac_edge(n);
      mac_edge(n);
      chk("t2_mclk_per", n, 20);
      frm.delete();
      frm.push_back(4'h6);
      en0 = en_total; b0 = busy_total; e0 = err_total;
      send_frame(10, -1, -1);
      wait_en_low();
      exp_frames++;
      chk("t2_cnt", frame_cnt, exp_frames);
      chk("t2_en_len", en_total - en0, 20);
      wait_busy_low();
      chk("t2_ipg_len", busy_total - b0, 480);
      chk("t2_no_err", err_total - e0, 0);

      // early restart 10 clks after frame end
      speed_100 = 1'b1;
      repeat (30) @(posedge clk);
      frm.delete();
      frm.push_back(4'hA); frm.push_back(4'hB); frm.push_back(4'hC); frm.push_back(4'h7);
      send_frame(1, -1, -1);
      wait_en_low();
      exp_frames++;
      repeat (10) @(posedge clk);
      e0 = err_total;
      frm.delete();
      for (int i = 1; i <= 6; i++) frm.push_back(4'(i));
      send_frame(1, -1, -1);
      wait_en_low();
      exp_frames++;
      b0 = busy_total;
      chk("t4_err_pulse", err_total - e0, 1);
      chk("t4_cnt", frame_cnt, exp_frames);
      wait_busy_low();
      chk("t4_ipg_len", busy_total - b0, 48);
      chk("t4_sb_empty", exp_q.size(), 0);

      // speed toggled mid-frame: current frame and its gap stay at 100M
      frm.delete();
      for (int i = 8; i <= 15; i++) frm.push_back(4'(i));
      en0 = en_total;
      send_frame(1, 3, -1);
      wait_en_low();
      exp_frames++;
      chk("t5_en_len", en_total - en0, 16);
      chk("t5_cnt", frame_cnt, exp_frames);
      b0 = busy_total;
      wait_busy_low();
      chk("t5_ipg_len", busy_total - b0, 48);
      repeat (30) @(posedge clk);
      mac_edge(n);
      mac_edge(n);
      chk("t5_mclk_per", n, 20);
      frm.delete();
      frm.push_back(4'h3); frm.push_back(4'hC);
      en0 = en_total;
      send_frame(10, -1, -1);
      wait_en_low();
      exp_frames++;
      chk("t5_en_len10", en_total - en0, 40);
      b0 = busy_total;
      wait_busy_low();
      chk("t5_ipg_len10", busy_total - b0, 480);
      speed_100 = 1'b1;
      repeat (30) @(posedge clk);

      // reset during the fifth nibble, then a clean frame
      chk("t6_cnt_pre", frame_cnt, exp_frames);
      frm.delete();
      for (int i = 1; i <= 10; i++) frm.push_back(4'(i));
      send_frame(1, -1, 4);
      frm.delete();
      frm.push_back(4'hF); frm.push_back(4'h0); frm.push_back(4'h5);
      en0 = en_total;
      send_frame(1, -1, -1);
      wait_en_low();
      exp_frames++;
      chk("t6_en_len", en_total - en0, 6);
      chk("t6_cnt", frame_cnt, exp_frames);
      wait_busy_low();
      chk("t6_sb_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
